fft_twiddle_sequencer: RTL and testbench
========================================

Name: fft_twiddle_sequencer

Overview:
Control stage directly upstream of the twiddle-factor RAMs (real and imaginary parts) in the radix-2 DIT FFT.
- Walks every stage / group / butterfly of an N-point transform.
- Drives the shared twiddle RAM read address and captures the combinational read data.
- Emits one registered butterfly descriptor per beat to the butterfly datapath under valid/ready: operand indices A and B, twiddle re/im, stage number, last flag.

Parameters:
LOG2N, 9, log2 of FFT size N; N = 2**LOG2N, LOG2N >= 2
WIDTH, 32, twiddle word width (matches twiddle RAM WIDTH)
TW_DEPTH, 2**(LOG2N-1), twiddle table depth N/2; address width $clog2(TW_DEPTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full transform sweep when idle
busy  out  1  high from accepted start until the last descriptor is accepted
done  out  1  one-cycle pulse after the last descriptor handshake
tw_addr  out  $clog2(TW_DEPTH)  twiddle RAM address (both RAMs)
tw_re_in  in  WIDTH  twiddle RAM real data (combinational read of tw_addr)
tw_im_in  in  WIDTH  twiddle RAM imaginary data (combinational read of tw_addr)
out_valid  out  1  descriptor valid
out_ready  in  1  consumer accepts descriptor
out_a_idx  out  LOG2N  upper butterfly operand index
out_b_idx  out  LOG2N  lower butterfly operand index
out_tw_re  out  WIDTH  registered twiddle real
out_tw_im  out  WIDTH  registered twiddle imaginary
out_stage  out  $clog2(LOG2N)  stage number 0..LOG2N-1
out_last  out  1  high on the final descriptor of the sweep

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; busy=0, done=0, out_valid=0, out_last=0; all output data registers 0; tw_addr=0.
- FSM IDLE -> RUN on start; RUN -> DRAIN after the last descriptor is loaded into the output register; DRAIN -> IDLE when that descriptor handshakes (out_valid & out_ready); done pulses in the cycle after that handshake.
- start while not IDLE is ignored.
- Counters:
  - s (stage, 0..LOG2N-1), half = 2**s.
  - g (group base, steps by 2*half, 0..N-2*half).
  - k (0..half-1).
  - Butterfly: a = g+k, b = g+k+half, tw_addr = k << (LOG2N-1-s).
  - Increment order: k first, then g, then s.
- tw_addr is driven combinationally from the current counters; tw_re_in/tw_im_in are sampled in the same cycle as the load.
- Load condition: state RUN and (!out_valid or out_ready). On load:
  - register a, b, tw data, s, and last = (s==LOG2N-1 and g==N-2*half and k==half-1);
  - set out_valid=1;
  - advance the counters.
- Without a load, out_valid and all out_* hold stable (no change while valid and not ready).
- In DRAIN, out_valid clears on handshake; no further loads.
- Throughput: one descriptor per cycle while out_ready=1; first out_valid appears 1 cycle after start is sampled.
- Total descriptors per sweep: LOG2N*N/2, exactly one with out_last=1.
- Stage wrap: after k, g, s all reach their maxima, no further counter increment.
- Async reset mid-sweep aborts immediately to the reset state; the next start restarts from s=g=k=0.

Test Plan:
- LOG2N=3, out_ready=1, pulse start -> 12 descriptors on consecutive cycles, 1 cycle after start:
  - (a,b,tw_addr) stage0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - out_last only on the 12th; done pulses 1 cycle later; busy low after.
- Twiddle RAM model with re=addr+100, im=addr+200 -> out_tw_re/out_tw_im match the tw_addr of each descriptor (e.g. stage2 descriptor 4: 103/203).
- Random out_ready (50%) -> identical descriptor sequence; out_* stable while valid & !ready; no drops or duplicates.
- start pulsed during RUN -> ignored, sequence unaffected; new start after done -> sequence repeats from (0,1,0).
- rst_n low at descriptor 5 -> out_valid=0, busy=0 immediately (asynchronously); new start -> full 12-descriptor sweep from the beginning.
- Default LOG2N=9 -> 2304 descriptors, max tw_addr 255, single out_last, single done pulse.

Source files
------------

// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT twiddle sequencer.
// Walks stage / group / butterfly for an N-point transform, drives the shared
// twiddle RAM address, and emits one registered butterfly descriptor per beat.
//
// Output handshake: a descriptor transfers on a rising clk edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, every
// out_* signal holds its value. out_valid never drops without a transfer.
module fft_twiddle_sequencer #(
  parameter int LOG2N    = 9,
  parameter int WIDTH    = 32,
  parameter int TW_DEPTH = 2**(LOG2N-1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(TW_DEPTH)-1:0] tw_addr,
  input  logic [WIDTH-1:0]            tw_re_in,
  input  logic [WIDTH-1:0]            tw_im_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LOG2N-1:0]            out_a_idx,
  output logic [LOG2N-1:0]            out_b_idx,
  output logic [WIDTH-1:0]            out_tw_re,
  output logic [WIDTH-1:0]            out_tw_im,
  output logic [$clog2(LOG2N)-1:0]    out_stage,
  output logic                        out_last
);

  localparam int AW = $clog2(TW_DEPTH);
  localparam int SW = $clog2(LOG2N);
  localparam int N  = 2**LOG2N;
  localparam logic [LOG2N:0] N_W = (LOG2N+1)'(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    s;
  logic [LOG2N-1:0] g;
  logic [LOG2N-1:0] k;

  logic [LOG2N:0]   half_w;
  logic [LOG2N:0]   g_last_w;
  logic [LOG2N-1:0] g_step;
  logic [LOG2N-1:0] a_cur;
  logic [LOG2N-1:0] b_cur;
  logic [SW-1:0]    shamt;
  logic             k_last;
  logic             g_last;
  logic             s_last;
  logic             sweep_last;
  logic             load;
  logic             handshake;

  // Butterfly geometry derived from the current counters.
  assign half_w     = (LOG2N+1)'(1) << s;
  assign g_last_w   = N_W - {half_w[LOG2N-1:0], 1'b0};
  assign g_step     = {half_w[LOG2N-2:0], 1'b0};
  assign a_cur      = g + k;
  assign b_cur      = a_cur + half_w[LOG2N-1:0];
  assign shamt      = SW'(LOG2N-1) - s;
  assign tw_addr    = AW'(k << shamt);
  assign k_last     = ({1'b0, k} == (half_w - (LOG2N+1)'(1)));
  assign g_last     = ({1'b0, g} == g_last_w);
  assign s_last     = (s == SW'(LOG2N-1));
  assign sweep_last = s_last && g_last && k_last;

  assign load      = (state == ST_RUN) && (!out_valid || out_ready);
  assign handshake = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);

  // Sweep control FSM and the done pulse after the final transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (load && sweep_last) state <= ST_DRAIN;
        ST_DRAIN: if (handshake) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                  end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage/group/butterfly counters: k fastest, then g, then s; hold at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      g <= '0;
      k <= '0;
    end else if (state == ST_IDLE && start) begin
      s <= '0;
      g <= '0;
      k <= '0;
    end else if (load) begin
      if (!k_last) begin
        k <= k + LOG2N'(1);
      end else if (!g_last) begin
        k <= '0;
        g <= g + g_step;
      end else if (!s_last) begin
        k <= '0;
        g <= '0;
        s <= s + SW'(1);
      end
    end
  end

  // Descriptor output register: load captures indices and RAM data together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a_idx <= '0;
      out_b_idx <= '0;
      out_tw_re <= '0;
      out_tw_im <= '0;
      out_stage <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_a_idx <= a_cur;
      out_b_idx <= b_cur;
      out_tw_re <= tw_re_in;
      out_tw_im <= tw_im_in;
      out_stage <= s;
      out_last  <= sweep_last;
    end else if (state == ST_DRAIN && handshake) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Testbench for fft_twiddle_sequencer: an 8-point instance exercised with
// table vectors, random backpressure, start pokes and reset aborts, and a
// default 512-point instance swept end to end against a loop-based model.
module tb_fft_twiddle_sequencer;

  typedef struct {
    int a;
    int b;
    int re;
    int im;
    int stage;
    bit last;
  } desc_t;

  typedef struct {
    int a;
    int b;
    int tw;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst_n, l_rst_n;

  // ---------------- small instance (LOG2N=3) ----------------
  logic        s_start, s_busy, s_done, s_valid, s_ready, s_last;
  logic [1:0]  s_addr;
  logic [31:0] s_re, s_im, s_tre, s_tim;
  logic [2:0]  s_a, s_b;
  logic [1:0]  s_stage;

  assign s_re = 32'(s_addr) + 32'd100;
  assign s_im = 32'(s_addr) + 32'd200;

  fft_twiddle_sequencer #(.LOG2N(3), .WIDTH(32)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .tw_addr(s_addr), .tw_re_in(s_re), .tw_im_in(s_im),
    .out_valid(s_valid), .out_ready(s_ready), .out_a_idx(s_a), .out_b_idx(s_b),
    .out_tw_re(s_tre), .out_tw_im(s_tim), .out_stage(s_stage), .out_last(s_last)
  );

  // ---------------- default instance (LOG2N=9) ----------------
  logic        l_start, l_busy, l_done, l_valid, l_ready, l_last;
  logic [7:0]  l_addr;
  logic [31:0] l_re, l_im, l_tre, l_tim;
  logic [8:0]  l_a, l_b;
  logic [3:0]  l_stage;

  assign l_re = 32'(l_addr) + 32'd100;
  assign l_im = 32'(l_addr) + 32'd200;

  fft_twiddle_sequencer dut_l (
    .clk(clk), .rst_n(l_rst_n), .start(l_start), .busy(l_busy), .done(l_done),
    .tw_addr(l_addr), .tw_re_in(l_re), .tw_im_in(l_im),
    .out_valid(l_valid), .out_ready(l_ready), .out_a_idx(l_a), .out_b_idx(l_b),
    .out_tw_re(l_tre), .out_tw_im(l_tim), .out_stage(l_stage), .out_last(l_last)
  );

  // ---------------- scoreboard ----------------
  int    tests_run = 0;
  int    tests_failed = 0;
  desc_t exp_q[$];
  desc_t got_q[$];
  vec_t  vec[12];

  task automatic check_int(input string name, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_desc(input string name, input desc_t got, input desc_t exp);
    tests_run++;
    if (got.a != exp.a || got.b != exp.b || got.re != exp.re || got.im != exp.im ||
        got.stage != exp.stage || got.last != exp.last) begin
      tests_failed++;
      $display("FAIL %s: got a=%0d b=%0d re=%0d im=%0d st=%0d last=%0d expected a=%0d b=%0d re=%0d im=%0d st=%0d last=%0d",
               name, got.a, got.b, got.re, got.im, got.stage, got.last,
               exp.a, exp.b, exp.re, exp.im, exp.stage, exp.last);
    end
  endtask

  // Reference: plain nested loops over stages, groups and butterflies.
  // Twiddle exponent for butterfly k in a stage of span 2*half is k*N/(2*half).
  function automatic void build_model(input int log2n);
    int n;
    desc_t d;
    n = 1 << log2n;
    exp_q.delete();
    for (int st = 0; st < log2n; st++) begin
      int half;
      half = 1 << st;
      for (int grp = 0; grp < n; grp += 2 * half) begin
        for (int kk = 0; kk < half; kk++) begin
          int tw;
          tw = kk * (n / 2) / half;
          d.a = grp + kk;
          d.b = grp + kk + half;
          d.re = tw + 100;
          d.im = tw + 200;
          d.stage = st;
          d.last = 1'b0;
          exp_q.push_back(d);
        end
      end
    end
    exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  function automatic desc_t sample_s();
    desc_t d;
    d.a = int'(s_a);
    d.b = int'(s_b);
    d.re = int'(s_tre);
    d.im = int'(s_tim);
    d.stage = int'(s_stage);
    d.last = s_last;
    return d;
  endfunction

  task automatic compare_model(input string tag);
    check_int({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_desc($sformatf("%s_desc%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  // ---------------- driver / monitor for the small instance ----------------
  // Called at posedge+1. Pulses start, then collects transfers under random
  // ready, checking hold-stability, first-valid latency and the done pulse.
  task automatic collect_small(input int ready_pct, input bit poke_start,
                               input int stop_after, output bit finished);
    int    first_valid;
    bit    hold;
    bit    seen_last;
    desc_t prev;
    desc_t cur;
    got_q.delete();
    hold = 1'b0;
    seen_last = 1'b0;
    first_valid = -1;
    finished = 1'b0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int cyc = 1; cyc <= 300 && !seen_last; cyc++) begin
      s_ready = ($urandom_range(99) < ready_pct);
      if (poke_start && got_q.size() == 3) s_start = 1'b1;
      @(negedge clk);
      cur = sample_s();
      if (cyc == 1) check_int("busy_after_start", s_busy, 1);
      if (hold) begin
        check_int("hold_valid", s_valid, 1);
        check_desc("hold_data", cur, prev);
      end
      if (s_valid && first_valid < 0) first_valid = cyc;
      hold = s_valid && !s_ready;
      prev = cur;
      if (s_valid && s_ready) begin
        got_q.push_back(cur);
        if (cur.last) seen_last = 1'b1;
      end
      if (stop_after > 0 && got_q.size() == stop_after) return;
      if (!seen_last) begin
        @(posedge clk); #1;
        s_start = 1'b0;
      end
    end
    check_int("first_valid_latency", first_valid, 2);
    check_int("sweep_reached_last", seen_last, 1);
    if (seen_last) begin
      @(posedge clk); #1;
      s_ready = 1'b0;
      @(negedge clk);
      check_int("done_pulse", s_done, 1);
      check_int("busy_low_after", s_busy, 0);
      check_int("valid_low_after", s_valid, 0);
      @(negedge clk);
      check_int("done_single", s_done, 0);
      @(posedge clk); #1;
      finished = 1'b1;
    end
  endtask

  // ---------------- default-size sweep ----------------
  task automatic run_large();
    int idx, lasts, dones, maxaddr, first, lastcyc, addr;
    desc_t d;
    build_model(9);
    idx = 0; lasts = 0; dones = 0; maxaddr = 0; first = -1; lastcyc = -1;
    l_ready = 1'b1;
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (l_done) dones++;
      if (l_valid && l_ready) begin
        if (first < 0) first = c;
        lastcyc = c;
        d.a = int'(l_a); d.b = int'(l_b); d.re = int'(l_tre); d.im = int'(l_tim);
        d.stage = int'(l_stage); d.last = l_last;
        if (idx < exp_q.size()) check_desc($sformatf("large_desc%0d", idx), d, exp_q[idx]);
        addr = d.re - 100;
        if (addr > maxaddr) maxaddr = addr;
        if (d.last) lasts++;
        idx++;
      end
      if (lastcyc > 0 && c > lastcyc + 3) break;
      @(posedge clk); #1;
    end
    check_int("large_count", idx, 2304);
    check_int("large_last_count", lasts, 1);
    check_int("large_done_count", dones, 1);
    check_int("large_max_addr", maxaddr, 255);
    check_int("large_first_latency", first, 2);
    check_int("large_back_to_back", lastcyc - first, 2303);
    check_int("large_busy_end", l_busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit fin;
    desc_t e;
    vec = '{'{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
            '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
            '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};
    s_rst_n = 1'b0; l_rst_n = 1'b0;
    s_start = 1'b0; l_start = 1'b0;
    s_ready = 1'b0; l_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_int("rst_valid", s_valid, 0);
    check_int("rst_busy", s_busy, 0);
    check_int("rst_done", s_done, 0);
    check_int("rst_last", s_last, 0);
    check_int("rst_addr", s_addr, 0);
    check_int("rst_a", s_a, 0);
    check_int("rst_b", s_b, 0);
    check_int("rst_re", s_tre, 0);
    #1;
    s_rst_n = 1'b1; l_rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven check of the 8-point sweep at full throughput.
    collect_small(100, 1'b0, 0, fin);
    check_int("table_count", got_q.size(), 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++) begin
      e.a = vec[i].a; e.b = vec[i].b;
      e.re = vec[i].tw + 100; e.im = vec[i].tw + 200;
      e.stage = i / 4; e.last = (i == 11);
      check_desc($sformatf("table%0d", i), got_q[i], e);
    end

    // Random backpressure; each new start repeats the sweep from (0,1,0).
    build_model(3);
    collect_small(50, 1'b0, 0, fin);
    compare_model("rand50");
    collect_small(30, 1'b0, 0, fin);
    compare_model("rand30");

    // start pulsed during RUN must be ignored.
    collect_small(60, 1'b1, 0, fin);
    compare_model("poke");

    // Async reset after the fifth descriptor, then a clean restart.
    collect_small(100, 1'b0, 5, fin);
    #1 s_rst_n = 1'b0;
    #1;
    check_int("abort_valid", s_valid, 0);
    check_int("abort_busy", s_busy, 0);
    check_int("abort_last", s_last, 0);
    #1 s_rst_n = 1'b1;
    @(posedge clk); #1;
    collect_small(70, 1'b0, 0, fin);
    compare_model("after_reset");

    run_large();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
